count_modn_updown: RTL and testbench



---
 rtl/count_modn_updown_if.sv | 17 +
 rtl/count_modn_updown.sv | 83 ++++++++
 tb/tb_count_modn_updown.sv | 136 +++++++++++++
 3 files changed

// File: rtl/count_modn_updown_if.sv
// Control/data bundle for count_modn_updown: count controls in, digit-packed count and status out.
interface count_modn_updown_if #(
  parameter int DIGITS = 2,
  parameter int W      = 4
);
  logic                CE;
  logic                UP;
  logic                LOAD;
  logic [DIGITS*W-1:0] LD_VAL;
  logic                CLR_OVF;
  logic [DIGITS*W-1:0] VAL;
  logic                TC;
  logic                OVF;

  modport master (output CE, UP, LOAD, LD_VAL, CLR_OVF, input VAL, TC, OVF);
  modport slave  (input CE, UP, LOAD, LD_VAL, CLR_OVF, output VAL, TC, OVF);
endinterface

// File: rtl/count_modn_updown.sv
// Multi-digit modulo-BASE up/down counter with parallel load, cascade TC and sticky OVF.
// Define COUNT_SAT_EN to saturate at the terminal value instead of wrapping.
module count_modn_updown #(
  parameter int DIGITS = 2,
  parameter int BASE   = 10,
  parameter int W      = 4
) (
  input logic                C1K,
  input logic                RST,
  count_modn_updown_if.slave bus
);

  localparam logic [W-1:0] MAXD = W'(BASE - 1);

  logic [DIGITS*W-1:0] val_p1;
  logic [DIGITS*W-1:0] nxt_p0;
  logic [DIGITS*W-1:0] ld_p0;
  logic [DIGITS-1:0]   lo_max;
  logic [DIGITS-1:0]   lo_zero;
  logic                ovf_p1;
  logic                all_max;
  logic                all_zero;
  logic                tc;
  logic                sat_hold;

  function automatic logic [W-1:0] clamp_digit(input logic [W-1:0] d);
    return (d > MAXD) ? MAXD : d;
  endfunction

  function automatic logic [W-1:0] step_digit(input logic [W-1:0] d, input logic up);
    if (up) return (d == MAXD) ? '0 : d + W'(1);
    return (d == '0) ? MAXD : d - W'(1);
  endfunction

  // lo_max[i]/lo_zero[i]: every digit below i is at BASE-1 / 0, i.e. digit i sees a carry/borrow
  always_comb begin
    lo_max     = '0;
    lo_zero    = '0;
    nxt_p0     = val_p1;
    ld_p0      = '0;
    lo_max[0]  = 1'b1;
    lo_zero[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      lo_max[i]  = lo_max[i-1]  & (val_p1[(i-1)*W +: W] == MAXD);
      lo_zero[i] = lo_zero[i-1] & (val_p1[(i-1)*W +: W] == '0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.UP ? lo_max[i] : lo_zero[i])
        nxt_p0[i*W +: W] = step_digit(val_p1[i*W +: W], bus.UP);
      ld_p0[i*W +: W] = clamp_digit(bus.LD_VAL[i*W +: W]);
    end
  end

  assign all_max  = lo_max[DIGITS-1]  & (val_p1[(DIGITS-1)*W +: W] == MAXD);
  assign all_zero = lo_zero[DIGITS-1] & (val_p1[(DIGITS-1)*W +: W] == '0);
  assign tc       = bus.CE & (bus.UP ? all_max : all_zero);

`ifdef COUNT_SAT_EN
  assign sat_hold = tc;
`else
  assign sat_hold = 1'b0;
`endif

  // Stage p1: registered count and sticky overflow; a wrap beats CLR_OVF in the same cycle
  always_ff @(posedge C1K) begin
    if (RST) begin
      val_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (bus.LOAD) begin
      val_p1 <= ld_p0;
      ovf_p1 <= 1'b0;
    end else begin
      if (bus.CE && !sat_hold) val_p1 <= nxt_p0;
      if (tc)                  ovf_p1 <= 1'b1;
      else if (bus.CLR_OVF)    ovf_p1 <= 1'b0;
    end
  end

  assign bus.VAL = val_p1;
  assign bus.TC  = tc;
  assign bus.OVF = ovf_p1;

endmodule

// File: tb/tb_count_modn_updown.sv
// Scoreboard bench for count_modn_updown (defaults: 2-digit BCD); expected values are hand-computed.
module tb_count_modn_updown;

  localparam int DIGITS = 2;
  localparam int BASE   = 10;
  localparam int W      = 4;

  typedef struct {
    logic [7:0] val;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  logic C1K = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  count_modn_updown_if #(.DIGITS(DIGITS), .W(W)) bus ();

  count_modn_updown #(.DIGITS(DIGITS), .BASE(BASE), .W(W)) dut (
    .C1K (C1K),
    .RST (RST),
    .bus (bus)
  );

  always #5 C1K = ~C1K;

  // Apply inputs, then let one rising edge sample them; inputs stay held afterwards.
  task automatic drive(input logic r, input logic ce, input logic up, input logic ld,
                       input logic [7:0] ldv, input logic clr);
    RST         = r;
    bus.CE      = ce;
    bus.UP      = up;
    bus.LOAD    = ld;
    bus.LD_VAL  = ldv;
    bus.CLR_OVF = clr;
    @(posedge C1K);
    #1;
  endtask

  // Queue an expectation and hold inputs until the monitor has sampled it.
  task automatic expect_out(input logic [7:0] v, input logic tc, input logic ovf, input string nm);
    exp_t e;
    e.val  = v;
    e.tc   = tc;
    e.ovf  = ovf;
    e.name = nm;
    sb.push_back(e);
    @(negedge C1K);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge C1K);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (bus.VAL !== e.val || bus.TC !== e.tc || bus.OVF !== e.ovf) begin
          n_fail++;
          $display("FAIL %s: got VAL=%h TC=%b OVF=%b, expected VAL=%h TC=%b OVF=%b",
                   e.name, bus.VAL, bus.TC, bus.OVF, e.val, e.tc, e.ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  localparam logic [7:0] GATE_VAL [8] = '{8'h06, 8'h06, 8'h07, 8'h07, 8'h08, 8'h08, 8'h09, 8'h09};

  initial begin : stimulus
    RST = 1'b1;
    bus.CE = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b0; bus.LD_VAL = '0; bus.CLR_OVF = 1'b0;
    @(negedge C1K);

    drive(1, 0, 1, 0, 8'h00, 0);  expect_out(8'h00, 0, 0, "reset");
    drive(1, 0, 1, 1, 8'h55, 0);  expect_out(8'h00, 0, 0, "rst_over_load");

    for (int i = 0; i < 9; i++) drive(0, 1, 1, 0, 8'h00, 0);
    expect_out(8'h09, 0, 0, "up_09");
    drive(0, 1, 1, 0, 8'h00, 0);  expect_out(8'h10, 0, 0, "up_carry_10");
    for (int i = 0; i < 89; i++) drive(0, 1, 1, 0, 8'h00, 0);
    expect_out(8'h99, 1, 0, "up_99_tc");
    drive(0, 1, 1, 0, 8'h00, 0);  expect_out(8'h00, 0, 1, "up_wrap");

    drive(1, 0, 1, 0, 8'h00, 0);  expect_out(8'h00, 0, 0, "reset2");
    drive(0, 1, 0, 0, 8'h00, 0);  expect_out(8'h99, 0, 1, "down_wrap");
    drive(0, 1, 0, 0, 8'h00, 0);  expect_out(8'h98, 0, 1, "down_98");
    drive(0, 0, 0, 1, 8'h10, 0);  expect_out(8'h10, 0, 0, "load_10");
    drive(0, 1, 0, 0, 8'h00, 0);  expect_out(8'h09, 0, 0, "down_borrow_09");

    drive(0, 0, 1, 1, 8'h05, 0);  expect_out(8'h05, 0, 0, "load_05");
    for (int i = 0; i < 8; i++) begin
      drive(0, (i % 2 == 0), 1, 0, 8'h00, 0);
      expect_out(GATE_VAL[i], 0, 0, $sformatf("ce_gate_%0d", i));
    end

    drive(0, 0, 1, 1, 8'h99, 0);  expect_out(8'h99, 0, 0, "load_99");
    drive(0, 1, 1, 0, 8'h00, 0);  expect_out(8'h00, 0, 1, "wrap_sets_ovf");
    drive(0, 1, 1, 1, 8'h3F, 0);  expect_out(8'h39, 0, 0, "load_clamp_lo");
    drive(0, 0, 1, 1, 8'hF2, 0);  expect_out(8'h92, 0, 0, "load_clamp_hi");

    drive(0, 0, 1, 1, 8'h99, 0);  expect_out(8'h99, 0, 0, "load_99b");
    drive(0, 1, 1, 0, 8'h00, 1);  expect_out(8'h00, 0, 1, "wrap_beats_clr");
    drive(0, 0, 1, 0, 8'h00, 1);  expect_out(8'h00, 0, 0, "clr_ovf");
    drive(0, 1, 0, 1, 8'h00, 0);  expect_out(8'h00, 1, 0, "tc_ignores_load");

`ifdef COUNT_SAT_EN
    drive(0, 0, 1, 1, 8'h99, 0);  expect_out(8'h99, 0, 0, "sat_load_99");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 8'h00, 0);
      expect_out(8'h99, 1, 1, $sformatf("sat_hold_%0d", i));
    end
    drive(0, 1, 0, 0, 8'h00, 0);  expect_out(8'h98, 0, 1, "sat_leave_down");
`endif

    repeat (2) @(posedge C1K);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
